// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - STAGES-deep pipelined two's-complement add/sub with valid/ready streams
// Define PIPELINED_ADDSUB_SAT_EN to saturate the result to the signed limit on overflow.
module pipelined_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);
  localparam int C = WIDTH / STAGES;

  logic              adv;
  logic [STAGES-1:0] v_q, v_d, c_q, c_d, x_v, x_c;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
  logic [WIDTH-1:0]  x_a [STAGES];
  logic [WIDTH-1:0]  x_b [STAGES];
  logic [WIDTH-1:0]  x_s [STAGES];
  logic [C:0]        chunk_t;
  logic              ovf_q, ovf_d;

  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  // Stage 0 folds sub/ci into effective operands; later stages take their predecessor's registers.
  always_comb begin
    x_v    = '0;
    x_c    = '0;
    x_v[0] = in_valid;
    x_c[0] = sub ? ~ci : ci;
    x_a[0] = a;
    x_b[0] = sub ? ~b : b;
    x_s[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      x_v[k] = v_q[k-1];
      x_c[k] = c_q[k-1];
      x_a[k] = a_q[k-1];
      x_b[k] = b_q[k-1];
      x_s[k] = s_q[k-1];
    end
  end

  always_comb begin
    v_d     = '0;
    c_d     = '0;
    chunk_t = '0;
    for (int k = 0; k < STAGES; k++) begin
      chunk_t = {1'b0, x_a[k][k*C +: C]} + {1'b0, x_b[k][k*C +: C]} + {{C{1'b0}}, x_c[k]};
      v_d[k]  = x_v[k];
      c_d[k]  = chunk_t[C];
      a_d[k]  = x_a[k];
      b_d[k]  = x_b[k];
      s_d[k]  = x_s[k];
      s_d[k][k*C +: C] = chunk_t[C-1:0];
    end
    // Carry into the MSB is recovered from the MSB sum bit of the effective operands.
    ovf_d = x_a[STAGES-1][WIDTH-1] ^ x_b[STAGES-1][WIDTH-1] ^ s_d[STAGES-1][WIDTH-1]
          ^ c_d[STAGES-1];
`ifdef PIPELINED_ADDSUB_SAT_EN
    if (ovf_d) begin
      s_d[STAGES-1] = x_a[STAGES-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                             : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (adv) begin
      v_q   <= v_d;
      c_q   <= c_d;
      ovf_q <= ovf_d;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign co        = c_q[STAGES-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb/tb_pipelined_addsub.sv - randomized self-checking bench for pipelined_addsub
// Four instances (STAGES 4,1,2,16) are exercised one at a time against a queue-based arithmetic model.
module tb_pipelined_addsub;
  localparam int W    = 16;
  localparam int NDUT = 4;

`ifdef PIPELINED_ADDSUB_SAT_EN
  localparam logic [W+1:0] EXP_ADD_OVF = {1'b0, 1'b1, 16'h7FFF};
  localparam logic [W+1:0] EXP_SUB_OVF = {1'b1, 1'b1, 16'h8000};
`else
  localparam logic [W+1:0] EXP_ADD_OVF = {1'b0, 1'b1, 16'h8000};
  localparam logic [W+1:0] EXP_SUB_OVF = {1'b1, 1'b1, 16'h7FFF};
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic [NDUT-1:0]     in_valid_v;
  logic [NDUT-1:0]     out_ready_v;
  wire  [NDUT-1:0]     in_ready_v;
  wire  [NDUT-1:0]     out_valid_v;
  wire  [NDUT-1:0]     co_v;
  wire  [NDUT-1:0]     ovf_v;
  wire  [W-1:0]        sum_v [NDUT];
  logic [W-1:0]        a, b;
  logic                ci, sub;

  int           n_cmp = 0;
  int           n_bad = 0;
  int           n_out = 0;
  logic         last_acc;
  logic [W+1:0] exp_q [$];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    pipelined_addsub #(
      .WIDTH (W),
      .STAGES((g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 2 : 16)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid_v[g]),
      .in_ready (in_ready_v[g]),
      .a        (a),
      .b        (b),
      .ci       (ci),
      .sub      (sub),
      .out_valid(out_valid_v[g]),
      .out_ready(out_ready_v[g]),
      .sum      (sum_v[g]),
      .co       (co_v[g]),
      .ovf      (ovf_v[g])
    );
  end

  function automatic int stg(input int g);
    return (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 2 : 16;
  endfunction

  // Reference: plain integer arithmetic on unsigned and signed views of the operands.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c, input logic s);
    int ur, sr;
    logic [W-1:0] r;
    logic co_m, ov;
    if (!s) begin
      ur   = int'(x) + int'(y) + int'(c);
      sr   = int'($signed(x)) + int'($signed(y)) + int'(c);
      co_m = (ur >= 65536);
    end else begin
      ur   = int'(x) - int'(y) - int'(c);
      sr   = int'($signed(x)) - int'($signed(y)) - int'(c);
      co_m = (ur >= 0);
    end
    r  = ur[W-1:0];
    ov = (sr > 32767) || (sr < -32768);
`ifdef PIPELINED_ADDSUB_SAT_EN
    if (ov) r = x[W-1] ? 16'h8000 : 16'h7FFF;
`endif
    return {co_m, ov, r};
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return W'($urandom);
    endcase
  endfunction

  // One clock: drive at the falling edge, then judge what the coming rising edge will accept/consume.
  task automatic cycle(input int sel, input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic ici, input logic isub, input logic ordy);
    logic [W+1:0] got, want;
    @(negedge clk);
    in_valid_v[sel]  = iv;
    out_ready_v[sel] = ordy;
    a   = ia;
    b   = ib;
    ci  = ici;
    sub = isub;
    #1;
    last_acc = iv && in_ready_v[sel];
    if (out_valid_v[sel] && ordy) begin
      got = {co_v[sel], ovf_v[sel], sum_v[sel]};
      n_cmp++;
      n_out++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard_extra dut%0d: got co/ovf/sum %h, required no result", sel, got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          n_bad++;
          $display("FAIL scoreboard dut%0d: got co/ovf/sum %h, required %h", sel, got, want);
        end
      end
    end
    if (last_acc) exp_q.push_back(model(ia, ib, ici, isub));
  endtask

  task automatic drain(input int sel);
    int k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      cycle(sel, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      k++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain dut%0d: %0d results outstanding, required 0", sel, exp_q.size());
      exp_q.delete();
    end
    repeat (stg(sel) + 2) cycle(sel, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    in_valid_v  = '0;
    out_ready_v = '1;
    a = '0; b = '0; ci = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    for (int g = 0; g < NDUT; g++) begin
      n_cmp++;
      if ({out_valid_v[g], co_v[g], ovf_v[g], sum_v[g], in_ready_v[g]} !== {3'b000, 16'h0000, 1'b1}) begin
        n_bad++;
        $display("FAIL reset_state dut%0d: got v/co/ovf/sum/rdy %b %b %b %h %b, required 0 0 0 0000 1",
                 g, out_valid_v[g], co_v[g], ovf_v[g], sum_v[g], in_ready_v[g]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_vector(input int sel, input logic [W-1:0] ia, input logic [W-1:0] ib,
                             input logic ici, input logic isub, input logic [W+1:0] want,
                             input string name);
    int k = 0;
    logic [W+1:0] got;
    cycle(sel, 1'b1, ia, ib, ici, isub, 1'b0);
    n_cmp++;
    if (!last_acc) begin
      n_bad++;
      $display("FAIL %s_accept dut%0d: got in_ready 0, required 1", name, sel);
    end
    while (!out_valid_v[sel] && k < 40) begin
      cycle(sel, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      k++;
    end
    n_cmp++;
    if (k != stg(sel)) begin
      n_bad++;
      $display("FAIL %s_latency dut%0d: got %0d register levels, required %0d", name, sel, k, stg(sel));
    end
    got = {co_v[sel], ovf_v[sel], sum_v[sel]};
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s dut%0d: got co/ovf/sum %h, required %h", name, sel, got, want);
    end
    cycle(sel, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    drain(sel);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] va [8];
    logic [W-1:0] vb [8];
    logic         vc [8];
    logic         vs [8];
    logic [W+1:0] snap, cur;
    logic         ordy;
    int nacc = 0;
    int c    = 0;
    for (int i = 0; i < 8; i++) begin
      va[i] = W'($urandom);
      vb[i] = W'($urandom);
      vc[i] = 1'($urandom);
      vs[i] = 1'($urandom);
    end
    snap  = '0;
    n_out = 0;
    while (nacc < 8 && c < 40) begin
      ordy = !(c >= 5 && c <= 7);
      cycle(0, 1'b1, va[nacc], vb[nacc], vc[nacc], vs[nacc], ordy);
      if (last_acc) nacc++;
      cur = {co_v[0], ovf_v[0], sum_v[0]};
      if (c >= 5 && c <= 7) begin
        n_cmp++;
        if ({out_valid_v[0], in_ready_v[0]} !== 2'b10) begin
          n_bad++;
          $display("FAIL hold_handshake c%0d: got out_valid/in_ready %b%b, required 10",
                   c, out_valid_v[0], in_ready_v[0]);
        end
        if (c == 5) snap = cur;
        else begin
          n_cmp++;
          if (cur !== snap) begin
            n_bad++;
            $display("FAIL hold_stable c%0d: got co/ovf/sum %h, required %h", c, cur, snap);
          end
        end
      end
      c++;
    end
    drain(0);
    n_cmp++;
    if (n_out != 8) begin
      n_bad++;
      $display("FAIL back_to_back_count: got %0d results, required 8", n_out);
    end
  endtask

  task automatic test_reset_flush();
    for (int i = 0; i < 3; i++) cycle(0, 1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    @(posedge clk);
    in_valid_v[0] = 1'b0;
    @(posedge clk);
    #2;
    n_cmp++;
    if (out_valid_v[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_pre: got out_valid %b, required 1", out_valid_v[0]);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid_v[0], co_v[0], ovf_v[0], sum_v[0]} !== 19'h0) begin
      n_bad++;
      $display("FAIL flush_async: got v/co/ovf/sum %b %b %b %h, required 0 0 0 0000",
               out_valid_v[0], co_v[0], ovf_v[0], sum_v[0]);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (in_ready_v[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_ready: got in_ready %b, required 1", in_ready_v[0]);
    end
    n_out = 0;
    repeat (20) cycle(0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (n_out != 0) begin
      n_bad++;
      $display("FAIL flush_ghost: got %0d results after reset, required 0", n_out);
    end
  endtask

  task automatic test_sweep(input int sel, input int nbeats);
    int nacc = 0;
    int c    = 0;
    logic [W-1:0] ia, ib;
    while (nacc < nbeats && c < nbeats * 8) begin
      ia = pick();
      ib = pick();
      cycle(sel, $urandom_range(0, 9) < 8, ia, ib, 1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0);
      if (last_acc) nacc++;
      c++;
    end
    n_cmp++;
    if (nacc != nbeats) begin
      n_bad++;
      $display("FAIL sweep_accept dut%0d: got %0d beats accepted, required %0d", sel, nacc, nbeats);
    end
    drain(sel);
  endtask

  initial begin
    test_reset();
    for (int g = 0; g < NDUT; g++)
      test_vector(g, 16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h0000}, "add_wrap");
    test_vector(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, EXP_ADD_OVF, "add_ovf");
    test_vector(0, 16'h0005, 16'h0007, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFE}, "sub_borrow");
    test_vector(0, 16'h8000, 16'h0001, 1'b0, 1'b1, EXP_SUB_OVF, "sub_ovf");
    test_vector(0, 16'h0000, 16'h0000, 1'b1, 1'b1, {1'b0, 1'b0, 16'hFFFF}, "sub_borrow_in");
    test_vector(0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, {1'b1, 1'b0, 16'hFFFF}, "add_carry_in");
    test_back_to_back();
    test_reset_flush();
    test_sweep(0, 2000);
    test_sweep(1, 4000);
    test_sweep(2, 4000);
    test_sweep(3, 4000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
